// File: rtl/cr_lane_trainer.sv
// Clock-recovery link trainer: drives the PHY and AUX channel through swing and
// pre-emphasis adjustment, falling back in link rate and then lane count.
module cr_lane_trainer #(
    parameter int LANES     = 4,
    parameter int MAX_SAME  = 5,
    parameter int MAX_LOOPS = 10,
    localparam int CW = $clog2(LANES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cfg_vld,
    input  logic [7:0]           cfg_bw,
    input  logic [CW-1:0]        cfg_lc,
    input  logic [1:0]           max_vtg,
    input  logic [1:0]           max_pre,
    input  logic                 status_vld,
    input  logic [LANES-1:0]     status_cr_done,
    input  logic [2*LANES-1:0]   status_adj_vtg,
    input  logic [2*LANES-1:0]   status_adj_pre,
    output logic                 aux_vld,
    output logic [1:0]           aux_cmd,
    output logic [19:0]          aux_addr,
    output logic [7:0]           aux_len,
    output logic [8*LANES-1:0]   aux_wdata,
    input  logic                 aux_ack,
    input  logic                 aux_fail,
    output logic                 tmr_start,
    input  logic                 tmr_fire,
    output logic                 phy_vld,
    output logic [7:0]           phy_bw,
    output logic [CW-1:0]        phy_lc,
    output logic [2*LANES-1:0]   lane_vtg,
    output logic [2*LANES-1:0]   lane_pre,
    output logic                 busy,
    output logic                 cr_ok,
    output logic                 cr_failed
);

    localparam int LW = $clog2(MAX_LOOPS + 1);
    localparam int SW = $clog2(MAX_SAME + 1);
    localparam logic [LW-1:0] LOOP_LAST = LW'(MAX_LOOPS - 1);
    localparam logic [SW-1:0] SAME_LAST = SW'(MAX_SAME - 1);

    typedef enum logic [3:0] {
        IDLE, PHY, WR_TPS, WR_DRV, WAIT, RD, STATUS, CHECK, REDUCE, DONE, FAIL
    } state_t;

    state_t               state, state_nxt;
    logic [7:0]           bw, orig_bw;
    logic [CW-1:0]        lc;
    logic [LW-1:0]        loop_cnt;
    logic [SW-1:0]        same_cnt;
    logic                 tmr_sent;

    logic [LANES-1:0]     st_done;
    logic [2*LANES-1:0]   st_vtg, st_pre;

    logic [LANES-1:0]     lane_mask, vtg_hit, same_hit;
    logic [2*LANES-1:0]   app_vtg, app_pre;
    logic [8*LANES-1:0]   drv_bytes;
    logic                 chk_done, chk_same, chk_reduce;
    logic [7:0]           bw_step;
    logic                 at_floor, reduce_ok;
    logic                 idle_like, accept, lc_ok;

    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Pre-emphasis headroom shrinks as swing grows: vtg + pre may not exceed 3.
    function automatic logic [1:0] clamp_pre(input logic [1:0] req, input logic [1:0] mp,
                                             input logic [1:0] vtg);
        return min2(min2(req, mp), 2'd3 - vtg);
    endfunction

    function automatic logic [7:0] drv_byte(input logic [1:0] vtg, input logic [1:0] pre,
                                            input logic [1:0] mv, input logic [1:0] mp);
        return {2'b00, (pre == mp), pre, (vtg == mv), vtg};
    endfunction

    assign idle_like = (state == IDLE) || (state == DONE) || (state == FAIL);
    assign accept    = idle_like && start && cfg_vld;
    assign lc_ok     = (cfg_lc != '0) && ((cfg_lc & (cfg_lc - CW'(1))) == '0)
                       && (int'(cfg_lc) <= LANES);

    always_comb begin
        lane_mask = '0;
        vtg_hit   = '0;
        same_hit  = '0;
        app_vtg   = '0;
        app_pre   = '0;
        drv_bytes = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (i < int'(lc));
            vtg_hit[i]   = (lane_vtg[2*i +: 2] == max_vtg);
            same_hit[i]  = (st_vtg[2*i +: 2] == lane_vtg[2*i +: 2])
                           && (st_pre[2*i +: 2] == lane_pre[2*i +: 2]);
            if (lane_mask[i]) begin
                app_vtg[2*i +: 2]   = min2(st_vtg[2*i +: 2], max_vtg);
                app_pre[2*i +: 2]   = clamp_pre(st_pre[2*i +: 2], max_pre,
                                                min2(st_vtg[2*i +: 2], max_vtg));
                drv_bytes[8*i +: 8] = drv_byte(lane_vtg[2*i +: 2], lane_pre[2*i +: 2],
                                               max_vtg, max_pre);
            end
        end
    end

    assign chk_done   = ((st_done & lane_mask) == lane_mask);
    assign chk_same   = &(same_hit | ~lane_mask);
    assign chk_reduce = (loop_cnt == LOOP_LAST) || (|(vtg_hit & lane_mask))
                        || (chk_same && (same_cnt == SAME_LAST));

    // Unknown rate codes are treated as the lowest rate.
    always_comb begin
        bw_step  = 8'h06;
        at_floor = 1'b0;
        case (bw)
            8'h1E:   bw_step = 8'h14;
            8'h14:   bw_step = 8'h0A;
            8'h0A:   bw_step = 8'h06;
            default: at_floor = 1'b1;
        endcase
    end

    assign reduce_ok = !at_floor || (lc > CW'(1));

    always_comb begin
        state_nxt = state;
        aux_vld   = 1'b0;
        aux_cmd   = 2'b00;
        aux_addr  = '0;
        aux_len   = '0;
        aux_wdata = '0;
        tmr_start = 1'b0;
        phy_vld   = 1'b0;
        case (state)
            IDLE, DONE, FAIL: begin
                if (accept) state_nxt = lc_ok ? PHY : FAIL;
            end
            PHY: begin
                phy_vld   = 1'b1;
                state_nxt = WR_TPS;
            end
            WR_TPS: begin
                aux_vld        = 1'b1;
                aux_addr       = 20'h00102;
                aux_wdata[7:0] = 8'h21;
                if (aux_ack) state_nxt = WR_DRV;
            end
            WR_DRV: begin
                aux_vld   = 1'b1;
                aux_addr  = 20'h00103;
                aux_len   = 8'(lc) - 8'd1;
                aux_wdata = drv_bytes;
                if (aux_ack) state_nxt = WAIT;
            end
            WAIT: begin
                tmr_start = !tmr_sent;
                if (tmr_sent && tmr_fire) state_nxt = RD;
            end
            RD: begin
                aux_vld  = 1'b1;
                aux_cmd  = 2'b01;
                aux_addr = 20'h00202;
                aux_len  = 8'd5;
                if (aux_ack) state_nxt = STATUS;
            end
            STATUS: begin
                if (status_vld) state_nxt = CHECK;
            end
            CHECK: begin
                if (chk_done)        state_nxt = DONE;
                else if (chk_reduce) state_nxt = REDUCE;
                else                 state_nxt = WR_DRV;
            end
            REDUCE: begin
                state_nxt = reduce_ok ? PHY : FAIL;
            end
            default: state_nxt = IDLE;
        endcase
        if (!idle_like && aux_fail) state_nxt = FAIL;
        if (rst) begin
            aux_vld   = 1'b0;
            tmr_start = 1'b0;
            phy_vld   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bw       <= '0;
            orig_bw  <= '0;
            lc       <= '0;
            lane_vtg <= '0;
            lane_pre <= '0;
            same_cnt <= '0;
            loop_cnt <= '0;
            tmr_sent <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr_sent <= (state == WAIT);
            if (accept) begin
                bw       <= cfg_bw;
                orig_bw  <= cfg_bw;
                lc       <= cfg_lc;
                lane_vtg <= '0;
                lane_pre <= '0;
                same_cnt <= '0;
                loop_cnt <= '0;
            end
            if ((state == CHECK) && !chk_done && !chk_reduce && (state_nxt == WR_DRV)) begin
                same_cnt <= chk_same ? same_cnt + SW'(1) : '0;
                loop_cnt <= loop_cnt + LW'(1);
                lane_vtg <= app_vtg;
                lane_pre <= app_pre;
            end
            if ((state == REDUCE) && (state_nxt == PHY)) begin
                if (!at_floor) begin
                    bw <= bw_step;
                end else begin
                    lc <= lc >> 1;
                    bw <= orig_bw;
                end
                lane_vtg <= '0;
                lane_pre <= '0;
                same_cnt <= '0;
                loop_cnt <= '0;
            end
        end
    end

    // Sink status snapshot consumed by CHECK.
    always_ff @(posedge clk) begin
        if ((state == STATUS) && status_vld) begin
            st_done <= status_cr_done;
            st_vtg  <= status_adj_vtg;
            st_pre  <= status_adj_pre;
        end
    end

    assign phy_bw    = bw;
    assign phy_lc    = lc;
    assign busy      = !idle_like;
    assign cr_ok     = (state == DONE);
    assign cr_failed = (state == FAIL);

endmodule

// File: tb/tb_cr_lane_trainer.sv
// Directed bench for cr_lane_trainer: an AUX/timer/status responder logs every
// transaction while scenario tasks start training and check the logs and outputs.
module tb_cr_lane_trainer;

    localparam int LANES = 4;
    localparam int CW    = 3;

    logic               clk = 1'b0;
    logic               rst, start, cfg_vld;
    logic [7:0]         cfg_bw;
    logic [CW-1:0]      cfg_lc;
    logic [1:0]         max_vtg, max_pre;
    logic               status_vld;
    logic [LANES-1:0]   status_cr_done;
    logic [2*LANES-1:0] status_adj_vtg, status_adj_pre;
    logic               aux_vld;
    logic [1:0]         aux_cmd;
    logic [19:0]        aux_addr;
    logic [7:0]         aux_len;
    logic [8*LANES-1:0] aux_wdata;
    logic               aux_ack, aux_fail, tmr_start, tmr_fire, phy_vld;
    logic [7:0]         phy_bw;
    logic [CW-1:0]      phy_lc;
    logic [2*LANES-1:0] lane_vtg, lane_pre;
    logic               busy, cr_ok, cr_failed;

    cr_lane_trainer #(.LANES(LANES), .MAX_SAME(5), .MAX_LOOPS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_vld(cfg_vld), .cfg_bw(cfg_bw),
        .cfg_lc(cfg_lc), .max_vtg(max_vtg), .max_pre(max_pre), .status_vld(status_vld),
        .status_cr_done(status_cr_done), .status_adj_vtg(status_adj_vtg),
        .status_adj_pre(status_adj_pre), .aux_vld(aux_vld), .aux_cmd(aux_cmd),
        .aux_addr(aux_addr), .aux_len(aux_len), .aux_wdata(aux_wdata), .aux_ack(aux_ack),
        .aux_fail(aux_fail), .tmr_start(tmr_start), .tmr_fire(tmr_fire), .phy_vld(phy_vld),
        .phy_bw(phy_bw), .phy_lc(phy_lc), .lane_vtg(lane_vtg), .lane_pre(lane_pre),
        .busy(busy), .cr_ok(cr_ok), .cr_failed(cr_failed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [19:0] addr;
        logic [7:0]  len;
        logic [31:0] wdata;
        logic [7:0]  vtg;
        logic [7:0]  pre;
    } aux_rec_t;

    typedef struct packed {
        logic [7:0]    bw;
        logic [CW-1:0] lc;
        logic [31:0]   rdc;
    } phy_rec_t;

    aux_rec_t aux_q[$];
    phy_rec_t phy_q[$];
    int       rd_cnt = 0;

    // Scenario controls, written only by the test sequence.
    logic [3:0] sc_done [4];
    logic [7:0] sc_vtg  [4];
    logic [7:0] sc_pre  [4];
    int         sc_last = 0;
    int         sc_base = 0;
    bit         fail_drv = 0, hold_tmr = 0, man_en = 0, man_ack = 0, man_fire = 0;

    int n_chk = 0;
    int n_fail = 0;

    // Sink/timer model: acks each AUX request at once, fires the timer two
    // cycles after tmr_start, and returns scripted status after each read.
    initial begin : responder
        int  tcnt;
        int  st_idx;
        bit  st_pend;
        aux_rec_t r;
        phy_rec_t p;
        tcnt = 0; st_idx = 0; st_pend = 0;
        aux_ack = 0; aux_fail = 0; tmr_fire = 0; status_vld = 0;
        status_cr_done = '0; status_adj_vtg = '0; status_adj_pre = '0;
        forever begin
            @(posedge clk); #1;
            aux_ack    = man_en ? man_ack : 1'b0;
            tmr_fire   = man_en ? man_fire : 1'b0;
            aux_fail   = 1'b0;
            status_vld = 1'b0;
            if (!man_en && !rst) begin
                if (st_pend) begin
                    status_vld     = 1'b1;
                    status_cr_done = sc_done[st_idx];
                    status_adj_vtg = sc_vtg[st_idx];
                    status_adj_pre = sc_pre[st_idx];
                    st_pend        = 0;
                end
                if (tcnt != 0) begin
                    tcnt--;
                    if (tcnt == 0) tmr_fire = 1'b1;
                end
                if (tmr_start && !hold_tmr) tcnt = 2;
                if (phy_vld) begin
                    p.bw = phy_bw; p.lc = phy_lc; p.rdc = rd_cnt;
                    phy_q.push_back(p);
                end
                if (aux_vld) begin
                    r.cmd = aux_cmd; r.addr = aux_addr; r.len = aux_len;
                    r.wdata = aux_wdata; r.vtg = lane_vtg; r.pre = lane_pre;
                    aux_q.push_back(r);
                    if (fail_drv && aux_addr == 20'h00103) begin
                        aux_fail = 1'b1;
                    end else begin
                        aux_ack = 1'b1;
                        if (aux_cmd == 2'b01) begin
                            st_idx  = rd_cnt - sc_base;
                            if (st_idx > sc_last) st_idx = sc_last;
                            rd_cnt++;
                            st_pend = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] bw, input logic [CW-1:0] lc);
        @(posedge clk); #1;
        sc_base = rd_cnt;
        start = 1'b1; cfg_vld = 1'b1; cfg_bw = bw; cfg_lc = lc;
        @(posedge clk); #1;
        start = 1'b0; cfg_vld = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic set_status(input int idx, input logic [3:0] d, input logic [7:0] v,
                              input logic [7:0] p);
        sc_done[idx] = d; sc_vtg[idx] = v; sc_pre[idx] = p;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; cfg_vld = 1'b1; cfg_bw = 8'h14; cfg_lc = 3'd4;
        max_vtg = 2'd3; max_pre = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, cr_ok, cr_failed, aux_vld, tmr_start, phy_vld, phy_bw, phy_lc} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0",
                {busy, cr_ok, cr_failed, aux_vld, tmr_start, phy_vld, phy_bw, phy_lc});
        end
        n_chk++;
        if ({aux_cmd, aux_addr, aux_len, aux_wdata, lane_vtg, lane_pre} !== '0) begin
            n_fail++; $display("FAIL reset_data: aux_addr=%h lane_vtg=%h want 0", aux_addr, lane_vtg);
        end
        rst = 1'b0; start = 1'b0; cfg_vld = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_happy;
        int ab, pb; bit ok;
        ab = aux_q.size(); pb = phy_q.size();
        set_status(0, 4'hF, 8'h00, 8'h00); sc_last = 0;
        do_start(8'h14, 3'd4);
        wait_idle(500, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL happy_timeout: busy=%b want 0", busy); end
        n_chk++; if (cr_ok !== 1'b1 || cr_failed !== 1'b0) begin
            n_fail++; $display("FAIL happy_result: cr_ok=%b cr_failed=%b want 1/0", cr_ok, cr_failed); end
        n_chk++; if (phy_q.size() - pb != 1 || phy_q[pb].bw !== 8'h14 || phy_q[pb].lc !== 3'd4) begin
            n_fail++; $display("FAIL happy_phy: n=%0d bw=%h lc=%0d want 1/14/4",
                phy_q.size() - pb, phy_q[pb].bw, phy_q[pb].lc); end
        n_chk++; if (aux_q.size() - ab != 3) begin
            n_fail++; $display("FAIL happy_aux_count: got %0d want 3", aux_q.size() - ab); end
        n_chk++; if ({aux_q[ab].cmd, aux_q[ab].addr, aux_q[ab].len, aux_q[ab].wdata}
                     !== {2'b00, 20'h00102, 8'd0, 32'h21}) begin
            n_fail++; $display("FAIL happy_tps: addr=%h len=%h data=%h want 00102/0/21",
                aux_q[ab].addr, aux_q[ab].len, aux_q[ab].wdata); end
        n_chk++; if ({aux_q[ab+1].cmd, aux_q[ab+1].addr, aux_q[ab+1].len, aux_q[ab+1].wdata}
                     !== {2'b00, 20'h00103, 8'd3, 32'h0}) begin
            n_fail++; $display("FAIL happy_drv: addr=%h len=%h data=%h want 00103/3/0",
                aux_q[ab+1].addr, aux_q[ab+1].len, aux_q[ab+1].wdata); end
        n_chk++; if ({aux_q[ab+2].cmd, aux_q[ab+2].addr, aux_q[ab+2].len} !== {2'b01, 20'h00202, 8'd5}) begin
            n_fail++; $display("FAIL happy_rd: cmd=%b addr=%h len=%h want 01/00202/5",
                aux_q[ab+2].cmd, aux_q[ab+2].addr, aux_q[ab+2].len); end
    endtask

    task automatic test_bad_lc;
        int ab, pb;
        ab = aux_q.size(); pb = phy_q.size();
        do_start(8'h14, 3'd3);
        n_chk++; if (cr_failed !== 1'b1 || cr_ok !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL badlc_state: cr_failed=%b cr_ok=%b busy=%b want 1/0/0",
                cr_failed, cr_ok, busy); end
        repeat (5) @(posedge clk);
        #1;
        n_chk++; if (aux_q.size() != ab || phy_q.size() != pb) begin
            n_fail++; $display("FAIL badlc_traffic: aux=%0d phy=%0d want 0/0",
                aux_q.size() - ab, phy_q.size() - pb); end
    endtask

    task automatic test_adjust;
        int ab; bit ok;
        ab = aux_q.size();
        set_status(0, 4'h0, 8'h55, 8'h55); set_status(1, 4'hF, 8'h55, 8'h55); sc_last = 1;
        do_start(8'h14, 3'd4);
        wait_idle(500, ok);
        n_chk++; if (!ok || cr_ok !== 1'b1) begin
            n_fail++; $display("FAIL adjust_result: ok=%b cr_ok=%b want 1/1", ok, cr_ok); end
        n_chk++; if (aux_q.size() - ab != 5) begin
            n_fail++; $display("FAIL adjust_aux_count: got %0d want 5", aux_q.size() - ab); end
        n_chk++; if (aux_q[ab+3].addr !== 20'h00103 || aux_q[ab+3].wdata !== 32'h09090909) begin
            n_fail++; $display("FAIL adjust_drv2: addr=%h data=%h want 00103/09090909",
                aux_q[ab+3].addr, aux_q[ab+3].wdata); end
        n_chk++; if (lane_vtg !== 8'h55 || lane_pre !== 8'h55) begin
            n_fail++; $display("FAIL adjust_lanes: vtg=%h pre=%h want 55/55", lane_vtg, lane_pre); end
    endtask

    task automatic test_same_stall;
        int pb; bit ok;
        pb = phy_q.size();
        set_status(0, 4'h0, 8'h00, 8'h00); sc_last = 0;
        do_start(8'h14, 3'd4);
        wait_idle(3000, ok);
        n_chk++; if (!ok || cr_failed !== 1'b1) begin
            n_fail++; $display("FAIL stall_result: ok=%b cr_failed=%b want 1/1", ok, cr_failed); end
        n_chk++; if (phy_q[pb+1].bw !== 8'h0A || phy_q[pb+1].lc !== 3'd4) begin
            n_fail++; $display("FAIL stall_rate: bw=%h lc=%0d want 0a/4", phy_q[pb+1].bw, phy_q[pb+1].lc); end
        n_chk++; if (phy_q[pb+1].rdc - phy_q[pb].rdc != 5) begin
            n_fail++; $display("FAIL stall_checks: got %0d want 5", phy_q[pb+1].rdc - phy_q[pb].rdc); end
        n_chk++; if (phy_q.size() - pb != 9 || phy_q[pb+3].bw !== 8'h14 || phy_q[pb+3].lc !== 3'd2) begin
            n_fail++; $display("FAIL stall_fallback: n=%0d bw3=%h lc3=%0d want 9/14/2",
                phy_q.size() - pb, phy_q[pb+3].bw, phy_q[pb+3].lc); end
    endtask

    task automatic test_fallback;
        int ab, pb; bit ok;
        logic [7:0]    exp_bw [4];
        logic [CW-1:0] exp_lc [4];
        exp_bw = '{8'h0A, 8'h06, 8'h0A, 8'h06};
        exp_lc = '{3'd2, 3'd2, 3'd1, 3'd1};
        ab = aux_q.size(); pb = phy_q.size();
        set_status(0, 4'h0, 8'h00, 8'h00); sc_last = 0;
        do_start(8'h0A, 3'd2);
        wait_idle(3000, ok);
        n_chk++; if (!ok || cr_failed !== 1'b1 || cr_ok !== 1'b0) begin
            n_fail++; $display("FAIL fallback_result: ok=%b cr_failed=%b cr_ok=%b want 1/1/0",
                ok, cr_failed, cr_ok); end
        n_chk++; if (phy_q.size() - pb != 4) begin
            n_fail++; $display("FAIL fallback_count: got %0d want 4", phy_q.size() - pb); end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (phy_q[pb+k].bw !== exp_bw[k] || phy_q[pb+k].lc !== exp_lc[k]) begin
                n_fail++; $display("FAIL fallback_phy%0d: bw=%h lc=%0d want %h/%0d",
                    k, phy_q[pb+k].bw, phy_q[pb+k].lc, exp_bw[k], exp_lc[k]);
            end
        end
        n_chk++; if (aux_q[ab+1].len !== 8'd1) begin
            n_fail++; $display("FAIL fallback_len: got %0d want 1", aux_q[ab+1].len); end
    endtask

    task automatic test_clamp;
        int ab, pb; bit ok;
        ab = aux_q.size(); pb = phy_q.size();
        max_vtg = 2'd2; max_pre = 2'd3;
        set_status(0, 4'h0, 8'hFF, 8'hFF); sc_last = 0;
        do_start(8'h1E, 3'd2);
        wait_idle(3000, ok);
        n_chk++; if (!ok || cr_failed !== 1'b1) begin
            n_fail++; $display("FAIL clamp_result: ok=%b cr_failed=%b want 1/1", ok, cr_failed); end
        n_chk++; if (aux_q[ab+3].wdata !== 32'h00000E0E || aux_q[ab+3].len !== 8'd1) begin
            n_fail++; $display("FAIL clamp_bytes: data=%h len=%0d want 00000e0e/1",
                aux_q[ab+3].wdata, aux_q[ab+3].len); end
        n_chk++; if (aux_q[ab+3].vtg !== 8'h0A || aux_q[ab+3].pre !== 8'h05) begin
            n_fail++; $display("FAIL clamp_lanes: vtg=%h pre=%h want 0a/05",
                aux_q[ab+3].vtg, aux_q[ab+3].pre); end
        n_chk++; if (phy_q[pb+1].bw !== 8'h14 || phy_q[pb+1].rdc - phy_q[pb].rdc != 2) begin
            n_fail++; $display("FAIL clamp_reduce: bw=%h checks=%0d want 14/2",
                phy_q[pb+1].bw, phy_q[pb+1].rdc - phy_q[pb].rdc); end
        max_vtg = 2'd3;
    endtask

    task automatic test_aux_fail;
        int ab; bit ok;
        ab = aux_q.size();
        set_status(0, 4'hF, 8'h00, 8'h00); sc_last = 0;
        fail_drv = 1;
        do_start(8'h14, 3'd4);
        wait_idle(500, ok);
        fail_drv = 0;
        n_chk++; if (!ok || cr_failed !== 1'b1 || cr_ok !== 1'b0) begin
            n_fail++; $display("FAIL auxfail_result: ok=%b cr_failed=%b cr_ok=%b want 1/1/0",
                ok, cr_failed, cr_ok); end
        n_chk++; if (aux_q.size() - ab != 2 || aux_vld !== 1'b0) begin
            n_fail++; $display("FAIL auxfail_traffic: n=%0d aux_vld=%b want 2/0", aux_q.size() - ab, aux_vld); end
    endtask

    task automatic test_rst_in_wait;
        bit got;
        got = 0;
        hold_tmr = 1;
        set_status(0, 4'hF, 8'h00, 8'h00); sc_last = 0;
        do_start(8'h14, 3'd4);
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk); #1;
            if (tmr_start) got = 1;
        end
        n_chk++; if (!got) begin n_fail++; $display("FAIL rstwait_reach: tmr_start=%b want 1", tmr_start); end
        rst = 1'b1;
        #1;
        n_chk++; if (tmr_start !== 1'b0 || aux_vld !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_same_cycle: tmr_start=%b aux_vld=%b want 0/0", tmr_start, aux_vld); end
        @(posedge clk); #1;
        n_chk++;
        if ({busy, cr_ok, cr_failed, aux_vld, tmr_start, phy_vld, phy_bw, phy_lc, lane_vtg, lane_pre,
             aux_addr, aux_len, aux_wdata} !== '0) begin
            n_fail++; $display("FAIL rstwait_outputs: busy=%b bw=%h lc=%0d aux_addr=%h want all 0",
                busy, phy_bw, phy_lc, aux_addr); end
        man_ack = 1; man_fire = 1; man_en = 1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b0 || aux_vld !== 1'b0 || tmr_start !== 1'b0 || phy_vld !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_stale: busy=%b aux_vld=%b tmr_start=%b phy_vld=%b want 0",
                busy, aux_vld, tmr_start, phy_vld); end
        man_en = 0; man_ack = 0; man_fire = 0; hold_tmr = 0;
    endtask

    initial begin
        test_reset();
        test_happy();
        test_bad_lc();
        test_adjust();
        test_same_stall();
        test_fallback();
        test_clamp();
        test_aux_fail();
        test_rst_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
